// File: rtl/tlul_to_reg_adapter.sv
// TL-UL device adapter driving a register-interface target, one transaction at a time.
// Define TLUL_TO_REG_ADAPTER_PIPELINE_EN to accept a new A beat as the D beat retires.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DUW = 4;

  typedef enum logic [2:0] {
    TlPutFullData    = 3'h0,
    TlPutPartialData = 3'h1,
    TlGet            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TlAccessAck     = 3'h0,
    TlAccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [TL_AW-1:0]  addr;
    logic [TL_DW-1:0]  wdata;
    logic [TL_DBW-1:0] wstrb;
  } reg_req_t;

  typedef struct packed {
    logic             ready;
    logic [TL_DW-1:0] rdata;
    logic             error;
  } reg_rsp_t;
endpackage

module tlul_to_reg_adapter #(
  parameter type req_t     = tlul_pkg::reg_req_t,
  parameter type rsp_t     = tlul_pkg::reg_rsp_t,
  parameter type tl_h2d_t  = tlul_pkg::tl_h2d_t,
  parameter type tl_d2h_t  = tlul_pkg::tl_d2h_t,
  parameter type tl_a_op_e = tlul_pkg::tl_a_op_e,
  parameter type tl_d_op_e = tlul_pkg::tl_d_op_e,
  parameter tl_a_op_e PutFullData    = tlul_pkg::TlPutFullData,
  parameter tl_a_op_e PutPartialData = tlul_pkg::TlPutPartialData,
  parameter tl_a_op_e Get            = tlul_pkg::TlGet,
  parameter tl_d_op_e AccessAck      = tlul_pkg::TlAccessAck,
  parameter tl_d_op_e AccessAckData  = tlul_pkg::TlAccessAckData
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o,
  output req_t    reg_req_o,
  input  rsp_t    reg_rsp_i
);
  localparam int AW  = tlul_pkg::TL_AW;
  localparam int DW  = tlul_pkg::TL_DW;
  localparam int DBW = tlul_pkg::TL_DBW;
  localparam int SZW = tlul_pkg::TL_SZW;
  localparam int AIW = tlul_pkg::TL_AIW;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_e;

  state_e         state_q, state_d;
  tl_a_op_e       op_q, op_d;
  logic [SZW-1:0] size_q, size_d;
  logic [AIW-1:0] src_q, src_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DBW-1:0] mask_q, mask_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;

  logic a_ready;
  logic accept;
  logic legal;
  logic align_ok;
  logic is_get;
  logic unused_a_param;

  assign unused_a_param = ^tl_i.a_param;
  assign is_get = (op_q == Get);

`ifdef TLUL_TO_REG_ADAPTER_PIPELINE_EN
  assign a_ready = (state_q == IDLE) ||
                   ((state_q == RSP) && tl_i.d_ready);
`else
  assign a_ready = (state_q == IDLE);
`endif

  assign accept = tl_i.a_valid & a_ready;

  // Natural alignment: low address bits below 2^size must be zero.
  always_comb begin
    align_ok = 1'b1;
    if (tl_i.a_size == 2'd1) begin
      align_ok = ~tl_i.a_address[0];
    end else if (tl_i.a_size == 2'd2) begin
      align_ok = (tl_i.a_address[1:0] == 2'b00);
    end
    legal = (tl_i.a_opcode inside {Get, PutFullData, PutPartialData})
            && (tl_i.a_size <= 2'd2)
            && align_ok;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    size_d  = size_q;
    src_d   = src_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      REQ: begin
        if (reg_rsp_i.ready) begin
          rdata_d = reg_rsp_i.rdata;
          err_d   = reg_rsp_i.error;
          state_d = RSP;
        end
      end
      RSP: begin
        if (tl_i.d_ready) state_d = IDLE;
      end
      default: ;
    endcase
    // A new beat overrides the retire-to-IDLE move when pipelined.
    if (accept) begin
      op_d    = tl_i.a_opcode;
      size_d  = tl_i.a_size;
      src_d   = tl_i.a_source;
      addr_d  = tl_i.a_address;
      mask_d  = tl_i.a_mask;
      data_d  = tl_i.a_data;
      rdata_d = '0;
      err_d   = ~legal;
      state_d = legal ? REQ : RSP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= tl_a_op_e'('0);
      size_q  <= '0;
      src_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      size_q  <= size_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    reg_req_o       = '0;
    reg_req_o.valid = (state_q == REQ);
    reg_req_o.write = ~is_get;
    reg_req_o.addr  = addr_q;
    reg_req_o.wdata = data_q;
    reg_req_o.wstrb = is_get ? '0 : mask_q;
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = a_ready;
    tl_o.d_valid  = (state_q == RSP);
    tl_o.d_opcode = is_get ? AccessAckData : AccessAck;
    tl_o.d_size   = size_q;
    tl_o.d_source = src_q;
    tl_o.d_data   = (is_get && !err_q) ? rdata_q : '0;
    tl_o.d_error  = err_q;
  end
endmodule

// File: tb/tb_tlul_to_reg_adapter.sv
// Randomized scoreboard bench for tlul_to_reg_adapter.
// Target and D-channel monitors run independently of the A-channel driver.
module tb_tlul_to_reg_adapter;
  import tlul_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  tl_h2d_t  tl_i;
  tl_h2d_t  a_ch;
  logic     d_rdy;
  tl_d2h_t  tl_o;
  reg_req_t req;
  reg_rsp_t rsp;

  always #5 clk = ~clk;

  always_comb begin
    tl_i = a_ch;
    tl_i.d_ready = d_rdy;
  end

  tlul_to_reg_adapter dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .tl_i     (tl_i),
    .tl_o     (tl_o),
    .reg_req_o(req),
    .reg_rsp_i(rsp)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dr_mode = 2;
  int d_cnt = 0;
  int d_hs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } tgt_t;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } exp_t;

  tgt_t tgt_q[$];
  exp_t sb_q[$];

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  task automatic fail_now(string n);
    checks++;
    errors++;
    $display("FAIL %s", n);
  endtask

  // Reference rules: legality, reg fields and D response from opcode/size/addr.
  task automatic send(input logic [2:0] op, input logic [1:0] size,
                      input logic [7:0] src, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data,
                      input logic [31:0] rdata, input logic err,
                      input int lat, output int acc);
    bit   is_get;
    bit   legal;
    tgt_t t;
    exp_t e;
    int   n;
    is_get = (op == 3'd4);
    legal  = (op == 3'd4 || op == 3'd0 || op == 3'd1) && (size <= 2'd2)
             && ((addr % (32'd1 << size)) == 0);
    if (legal) begin
      t.write = !is_get;
      t.addr  = addr;
      t.wdata = data;
      t.wstrb = is_get ? 4'h0 : mask;
      t.rdata = rdata;
      t.err   = err;
      t.lat   = lat;
      tgt_q.push_back(t);
    end
    e.op   = is_get ? 3'd1 : 3'd0;
    e.size = size;
    e.src  = src;
    e.data = (legal && is_get && !err) ? rdata : 32'h0;
    e.err  = legal ? err : 1'b1;
    sb_q.push_back(e);
    a_ch.a_valid   = 1'b1;
    a_ch.a_opcode  = tl_a_op_e'(op);
    a_ch.a_param   = 3'($urandom);
    a_ch.a_size    = size;
    a_ch.a_source  = src;
    a_ch.a_address = addr;
    a_ch.a_mask    = mask;
    a_ch.a_data    = data;
    acc = -1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tl_o.a_ready) break;
    end
    if (n == 200) fail_now("a_accept_timeout");
    acc = cyc;
    @(posedge clk);
    #1;
    a_ch.a_valid = 1'b0;
  endtask

  task automatic wait_idle(string n);
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && tgt_q.size() == 0
          && !tl_o.d_valid && !req.valid) break;
    end
    if (k == 600) fail_now(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    d_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (dr_mode)
        0: d_rdy = ($urandom % 4) != 0;
        1: d_rdy = 1'b0;
        default: d_rdy = 1'b1;
      endcase
    end
  end

  // Register target model.
  initial begin
    tgt_t cur;
    bit   act;
    int   left;
    act = 0;
    left = 0;
    rsp = '0;
    forever begin
      @(negedge clk);
      rsp.ready = 1'b0;
      if (!rst_n) begin
        act = 0;
        continue;
      end
      if (req.valid) begin
        if (!act) begin
          if (tgt_q.size() == 0) begin
            fail_now("reg_unexpected_valid");
            continue;
          end
          cur = tgt_q.pop_front();
          act = 1;
          left = cur.lat;
        end
        chk("reg_write", req.write, cur.write);
        chk("reg_addr", req.addr, cur.addr);
        chk("reg_wdata", req.wdata, cur.wdata);
        chk("reg_wstrb", req.wstrb, cur.wstrb);
        if (left == 0) begin
          rsp.ready = 1'b1;
          rsp.rdata = cur.rdata;
          rsp.error = cur.err;
          act = 0;
        end else begin
          left--;
          rsp.rdata = $urandom;
          rsp.error = 1'($urandom);
        end
      end
    end
  end

  // D-channel monitor.
  initial begin
    exp_t e;
    bit   have;
    have = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 0;
        continue;
      end
      if (tl_o.d_valid) begin
        if (!have) begin
          if (sb_q.size() == 0) begin
            fail_now("d_unexpected_valid");
            continue;
          end
          e = sb_q.pop_front();
          have = 1;
        end
        chk("d_opcode", tl_o.d_opcode, e.op);
        chk("d_size", tl_o.d_size, e.size);
        chk("d_source", tl_o.d_source, e.src);
        chk("d_data", tl_o.d_data, e.data);
        chk("d_error", tl_o.d_error, e.err);
        chk("d_zero_fields",
            {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 0);
`ifdef TLUL_TO_REG_ADAPTER_PIPELINE_EN
        chk("a_ready_in_rsp", tl_o.a_ready, tl_i.d_ready);
`else
        chk("a_ready_in_rsp", tl_o.a_ready, 0);
`endif
        if (tl_i.d_ready) begin
          have = 0;
          d_cnt++;
          d_hs_q.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    int a2;
    int d1;
    int dc;
    int k;
    logic [2:0] op;
    logic [1:0] sz;
    logic [31:0] ad;
    a_ch = '0;
    #12;
    chk("rst_d_valid", tl_o.d_valid, 0);
    chk("rst_reg_valid", req.valid, 0);
    chk("rst_a_ready", tl_o.a_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_a_ready", tl_o.a_ready, 1);

    send(3'd4, 2'd2, 8'd3, 32'h10, 4'hF, 32'h0,
         32'hDEADBEEF, 1'b0, 2, a1);
    chk("get_reg_valid_n1", req.valid, 1);
    wait_idle("get_timeout");

    send(3'd1, 2'd2, 8'd5, 32'h24, 4'b0011, 32'h0000ABCD,
         32'h55AA55AA, 1'b1, 1, a1);
    wait_idle("putp_timeout");

    send(3'd4, 2'd2, 8'd7, 32'h02, 4'hF, 32'h0,
         32'h0, 1'b0, 0, a1);
    chk("illegal_d_valid_n1", tl_o.d_valid, 1);
    chk("illegal_no_reg", req.valid, 0);
    wait_idle("illegal_timeout");

    send(3'd4, 2'd0, 8'd9, 32'h41, 4'h2, 32'h0,
         32'hCAFEF00D, 1'b0, 0, a1);
    chk("zw_req_one", req.valid, 1);
    @(posedge clk);
    #1;
    chk("zw_req_drop", req.valid, 0);
    chk("zw_d_valid", tl_o.d_valid, 1);
    wait_idle("zw_timeout");

    dr_mode = 1;
    dc = d_cnt;
    send(3'd0, 2'd2, 8'd11, 32'h30, 4'hF, 32'h12345678,
         32'h0, 1'b0, 0, a1);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tl_o.d_valid) break;
    end
    if (k == 50) fail_now("stall_d_timeout");
    repeat (5) begin
      @(negedge clk);
      chk("stall_d_valid", tl_o.d_valid, 1);
      chk("stall_a_ready", tl_o.a_ready, 0);
    end
    chk("stall_not_retired", d_cnt, dc);
    dr_mode = 2;
    wait_idle("stall_timeout");
    chk("stall_retired", d_cnt, dc + 1);

    d_hs_q.delete();
    send(3'd0, 2'd2, 8'd1, 32'h50, 4'hF, 32'h11111111,
         32'h0, 1'b0, 0, a1);
    send(3'd0, 2'd2, 8'd2, 32'h54, 4'hF, 32'h22222222,
         32'h0, 1'b0, 0, a2);
    wait_idle("b2b_timeout");
    d1 = (d_hs_q.size() > 0) ? d_hs_q[0] : -100;
    chk("b2b_min_latency", 64'(d1 - a1), 2);
`ifdef TLUL_TO_REG_ADAPTER_PIPELINE_EN
    chk("b2b_gap", 64'(a2 - d1), 0);
`else
    chk("b2b_gap", 64'(a2 - d1), 1);
`endif

    dr_mode = 0;
    for (int i = 0; i < 150; i++) begin
      k = $urandom % 8;
      if (k < 3) op = 3'd4;
      else if (k < 5) op = 3'd0;
      else if (k < 7) op = 3'd1;
      else begin
        op = 3'($urandom_range(2, 7));
        if (op == 3'd4) op = 3'd3;
      end
      sz = ($urandom % 5 == 0) ? 2'($urandom) : 2'd2;
      ad = $urandom & 32'h0000_0FFC;
      if ($urandom % 6 == 0) ad = ad | 32'($urandom % 4);
      send(op, sz, 8'($urandom), ad, 4'($urandom), $urandom,
           $urandom, ($urandom % 5) == 0, $urandom % 4, a1);
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
    end
    dr_mode = 2;
    wait_idle("random_timeout");

    dc = d_cnt;
    send(3'd4, 2'd2, 8'd4, 32'h40, 4'hF, 32'h0,
         32'h0BADF00D, 1'b0, 20, a1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_d_valid", tl_o.d_valid, 0);
    chk("midrst_reg_valid", req.valid, 0);
    chk("midrst_a_ready", tl_o.a_ready, 1);
    sb_q.delete();
    tgt_q.delete();
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("postrst_reg_valid", req.valid, 0);
    chk("postrst_d_valid", tl_o.d_valid, 0);
    chk("postrst_no_d", d_cnt, dc);
    chk("queues_empty", 64'(sb_q.size() + tgt_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
